// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types, constants and helpers for the multicycle divider
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;
    localparam int DIV_MAX_WIDTH     = 64;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    // Divide-by-zero quotient: all ones in the low `width` bits; callers slice to their width.
    function automatic logic [DIV_MAX_WIDTH-1:0] div_zero_quotient(input int width);
        logic [DIV_MAX_WIDTH-1:0] r_ones;
        for (int i = 0; i < DIV_MAX_WIDTH; i++) begin
            r_ones[i] = (i < width);
        end
        return r_ones;
    endfunction

endpackage

// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - request/result bundle between the core and the divide sequencer
interface div_seq_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) ();

    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, is_signed, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, is_signed, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   i_rem,
    input  logic             i_quo_msb,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_rem,
    output logic             o_quo_bit
);

    logic [WIDTH+1:0] w_shifted;
    logic [WIDTH:0]   w_diff;

    assign w_shifted = {i_rem, i_quo_msb};
    assign o_quo_bit = (w_shifted >= {2'b00, i_divisor});
    // When the subtract succeeds the true difference is below the divisor, so WIDTH+1 bits suffice.
    assign w_diff    = w_shifted[WIDTH:0] - {1'b0, i_divisor};
    assign o_rem     = o_quo_bit ? w_diff : w_shifted[WIDTH:0];

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multicycle restoring divider with sign fix-up and divide-by-zero handling
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    div_seq_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic             w_busy;
    logic             w_done;

    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div_mag;
    logic [CW-1:0]    r_cnt;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dbz;

    logic             w_div_zero;
    logic             w_dvd_neg;
    logic             w_dvs_neg;
    logic [WIDTH-1:0] w_dvd_mag;
    logic [WIDTH-1:0] w_dvs_mag;
    logic [WIDTH:0]   w_step_rem;
    logic             w_step_bit;
    logic [WIDTH-1:0] w_fix_quo;
    logic [WIDTH-1:0] w_fix_rem;
    logic [DIV_MAX_WIDTH-1:0] w_zero_q_full;
    logic [WIDTH-1:0] w_zero_q;

    assign w_div_zero    = (bus.divisor == '0);
    assign w_dvd_neg     = bus.is_signed & bus.dividend[WIDTH-1];
    assign w_dvs_neg     = bus.is_signed & bus.divisor[WIDTH-1];
    // Negating MIN yields MIN, which read as unsigned is exactly its magnitude.
    assign w_dvd_mag     = w_dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    assign w_dvs_mag     = w_dvs_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    assign w_zero_q_full = div_zero_quotient(WIDTH);
    assign w_zero_q      = w_zero_q_full[WIDTH-1:0];

    assign w_fix_quo = r_neg_q ? (~r_quo + 1'b1) : r_quo;
    assign w_fix_rem = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_rem     (r_rem),
        .i_quo_msb (r_quo[WIDTH-1]),
        .i_divisor (r_div_mag),
        .o_rem     (w_step_rem),
        .o_quo_bit (w_step_bit)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_next_state = w_div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == '0) begin
                    w_next_state = S_FIX;
                end
            end
            S_FIX: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Result registers are only written on the edges that enter DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem       <= '0;
            r_quo       <= '0;
            r_div_mag   <= '0;
            r_cnt       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dbz       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_neg_q   <= w_dvd_neg ^ w_dvs_neg;
                        r_neg_r   <= w_dvd_neg;
                        r_div_mag <= w_dvs_mag;
                        r_quo     <= w_dvd_mag;
                        r_rem     <= '0;
                        r_cnt     <= CW'(WIDTH - 1);
                        if (w_div_zero) begin
                            r_quotient  <= w_zero_q;
                            r_remainder <= bus.dividend;
                            r_dbz       <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    r_rem <= w_step_rem;
                    r_quo <= {r_quo[WIDTH-2:0], w_step_bit};
                    r_cnt <= r_cnt - CW'(1);
                end
                S_FIX: begin
                    r_quotient  <= w_fix_quo;
                    r_remainder <= w_fix_rem;
                    r_dbz       <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - directed self-checking bench for div_seq
module tb_div_seq;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    div_seq_if #(.WIDTH(32)) bus ();

    div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    // Issues an op in the current cycle (cycle 0) and returns in the cycle after done.
    // A non-zero inj pulses start with 9/3 in that cycle while the divider is busy.
    task automatic run_op(input string name, input logic sg, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_q,
                          input logic [31:0] exp_r, input logic exp_z,
                          input int exp_lat, input int inj);
        int   cyc;
        logic busy_bad;
        busy_bad      = 1'b0;
        bus.start     = 1'b1;
        bus.is_signed = sg;
        bus.dividend  = a;
        bus.divisor   = b;
        tick();
        bus.start = 1'b0;
        for (cyc = 1; cyc < 100; cyc++) begin
            if (cyc == inj) begin
                bus.start     = 1'b1;
                bus.is_signed = 1'b0;
                bus.dividend  = 32'd9;
                bus.divisor   = 32'd3;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) break;
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
            tick();
        end
        bus.start = 1'b0;
        check({name, "_latency"}, cyc, exp_lat);
        check({name, "_busy_run"}, {31'd0, busy_bad}, 32'd0);
        check({name, "_busy_done"}, {31'd0, bus.busy}, 32'd1);
        check({name, "_quotient"}, bus.quotient, exp_q);
        check({name, "_remainder"}, bus.remainder, exp_r);
        check({name, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_z});
        tick();
        check({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_done_after"}, {31'd0, bus.done}, 32'd0);
        check({name, "_quotient_held"}, bus.quotient, exp_q);
    endtask

    initial begin
        int n_done;
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        tick();
        tick();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_quotient", bus.quotient, 32'd0);
        check("rst_remainder", bus.remainder, 32'd0);
        check("rst_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        reset = 1'b1;
        tick();

        run_op("u100_7",   1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 34, 0);
        run_op("s-100_7",  1'b1, 32'hFFFFFF9C,   32'd7,        32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0, 34, 0);
        run_op("s100_-7",  1'b1, 32'd100,        32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 34, 0);
        run_op("u5_0",     1'b0, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1,  0);
        run_op("s5_0",     1'b1, 32'd5,          32'd0,        32'hFFFFFFFF, 32'd5,        1'b1, 1,  0);
        run_op("smin_-1",  1'b1, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0, 34, 0);
        run_op("umax_1",   1'b0, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, 32'd0,        1'b0, 34, 0);
        run_op("inj_ign",  1'b0, 32'd100,        32'd7,        32'd14,       32'd2,        1'b0, 34, 10);
        run_op("b2b",      1'b0, 32'd1000,       32'd10,       32'd100,      32'd0,        1'b0, 34, 0);
        run_op("s-7_2",    1'b1, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 0);

        bus.start     = 1'b1;
        bus.is_signed = 1'b0;
        bus.dividend  = 32'd1000;
        bus.divisor   = 32'd3;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_quotient", bus.quotient, 32'd0);
        check("abort_remainder", bus.remainder, 32'd0);
        check("abort_dbz", {31'd0, bus.div_by_zero}, 32'd0);
        tick();
        tick();
        reset  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done === 1'b1) n_done++;
        end
        check("abort_no_done", n_done, 32'd0);
        check("abort_idle", {31'd0, bus.busy}, 32'd0);

        run_op("post_rst", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
